fpga_test_step_mac_acc: RTL and testbench
=========================================

Name: fpga_test_step_mac_acc

Overview:
- Downstream consumer of the step multiplier's 30-bit signed product stream (15-bit unsigned × 15-bit signed).
- Accumulates a programmable-length burst of products, rounds the Q14 sum back to integer scale, saturates it to 16 bits and presents it on a valid/ready result port.
- Sits between the multiplier output register and the step-output FIFO.

Parameters:
- PROD_WIDTH, 30, product input width (signed)
- ACC_WIDTH, 38, accumulator width; covers 255 × full-scale product with no overflow
- LEN_WIDTH, 8, burst-length field width (1..255 products)
- FRAC_SHIFT, 14, fractional bits removed at output (Q14 → integer)
- OUT_WIDTH, 16, result width (signed, saturated)

Ports:
- ap_clk  in  1  sole clock; all logic on rising edge
- ap_rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE
- len  in  LEN_WIDTH  number of products in burst; sampled with start
- prod_din  in  PROD_WIDTH  signed product from multiplier
- prod_valid  in  1  prod_din valid
- prod_ready  out  1  block accepts prod_din this cycle
- res_dout  out  OUT_WIDTH  rounded, saturated signed result
- res_valid  out  1  res_dout valid
- res_ready  in  1  downstream accepts result
- sat_flag  out  1  result was clipped; qualified by res_valid
- busy  out  1  high in ACC and OUT

Behaviour:
- Clock and reset: one clock, ap_clk. Reset ap_rst is asynchronous and active-high. On assertion, immediately: state=IDLE, acc=0, count=0, prod_ready=0, res_valid=0, res_dout=0, sat_flag=0, busy=0.
- Reset mid-burst discards the partial sum. No result is produced for an aborted burst.
- IDLE: prod_ready=0, busy=0.
  - start=1, len≠0: latch len, clear acc and count, go to ACC.
  - start=1, len=0: go to OUT with sum 0. res_valid=1 on the next cycle with res_dout=0, sat_flag=0.
- ACC: prod_ready=1 (combinational from state only; no dependence on prod_valid).
  - Beat = prod_valid & prod_ready.
  - On each beat: acc <= acc + sign_extend(prod_din), count <= count+1.
  - The beat with count == len−1 is the last beat. Its sum goes through round/saturate and is registered into res_dout/sat_flag. State becomes OUT, so res_valid=1 the cycle after the last beat (latency 1).
  - prod_valid low stalls the burst indefinitely with acc held.
- OUT: prod_ready=0. res_valid=1 and res_dout/sat_flag stay stable until res_ready=1. On that handshake: res_valid=0 next cycle, go to IDLE.
- start is ignored in ACC and OUT. len changes after latching have no effect.
- Round: r = (sum + 2^(FRAC_SHIFT−1)) >>> FRAC_SHIFT (arithmetic shift, round-half-up toward +inf). The computation is done at ACC_WIDTH+1 bits so the rounding add cannot wrap.
- Saturate:
  - r > 2^(OUT_WIDTH−1)−1 gives 32767 with sat_flag=1.
  - r < −2^(OUT_WIDTH−1) gives −32768 with sat_flag=1.
  - Otherwise res_dout = r[OUT_WIDTH−1:0] and sat_flag=0.
- Throughput: a new start is accepted at the earliest in the cycle after the result handshake. Minimum burst period is len+2 cycles.
- No combinational path from any input to res_dout.

Test Plan:
- Reset, then len=1, prod_din=1638400 (100.0 in Q14), valid held high → prod_ready high 1 cycle; res_valid one cycle after the beat; res_dout=100, sat_flag=0.
- Rounding, len=1: prod 8192 → 1; prod −8192 → 0; prod 24575 → 1; prod −24577 → −2.
- Saturation, len=4, four × 268435456 → 32767, sat_flag=1. Four × −268435456 → −32768, sat_flag=1. 255 × −268435456 → −32768 with no wrap.
- Stalls and backpressure, len=3, prod_valid toggling 1,0,0,1,0,1 with values 16384, 32768, −16384 → res_dout=2 after the third beat. Then hold res_ready=0 for 5 cycles → res_valid and res_dout stay unchanged. Pulsing start during this window is ignored. A result handshake is followed by a return to IDLE.
- len=0 start → res_valid next cycle with res_dout=0, sat_flag=0, and no beats accepted.
- Assert ap_rst asynchronously after 2 of 5 beats → all outputs 0 immediately. A new len=2 burst of 16384, 16384 then gives res_dout=2, proving the accumulator was cleared.

Source files
------------

// File: rtl/fpga_test_step_mac_acc.sv
// fpga_test_step_mac_acc
// Accumulates a programmable-length burst of signed Q14 products from the
// step multiplier, rounds the sum to integer scale, saturates it to a signed
// OUT_WIDTH result and hands it downstream over a valid/ready port.
//
// Ports:
//   ap_clk      sole clock, rising edge
//   ap_rst      asynchronous active-high reset
//   start       one-cycle burst request, sampled only in IDLE
//   len         products in the burst, latched with start (0 = empty burst)
//   prod_din    signed product from the multiplier
//   prod_valid  prod_din valid
//   prod_ready  product accepted this cycle (high throughout ACC)
//   res_dout    rounded, saturated signed result (registered)
//   res_valid   res_dout valid (high throughout OUT)
//   res_ready   downstream accepts the result
//   sat_flag    result was clipped, qualified by res_valid
//   busy        high in ACC and OUT
//
// state | meaning
// IDLE  | waiting for start
// ACC   | accepting products into the accumulator
// OUT   | holding the result until res_ready

module fpga_test_step_mac_acc #(
  parameter int PROD_WIDTH = 30,
  parameter int ACC_WIDTH  = 38,
  parameter int LEN_WIDTH  = 8,
  parameter int FRAC_SHIFT = 14,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         len,
  input  logic signed [PROD_WIDTH-1:0] prod_din,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  output logic signed [OUT_WIDTH-1:0]  res_dout,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         sat_flag,
  output logic                         busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_e;

  // Rounding constant and saturation limits, all at ACC_WIDTH+1 bits so the
  // rounding add can never wrap.
  localparam logic signed [ACC_WIDTH:0] RND_HALF =
    {{(ACC_WIDTH-FRAC_SHIFT+1){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  state_e                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [LEN_WIDTH-1:0]         count_q, count_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d;
  logic signed [OUT_WIDTH-1:0]  res_q, res_d;
  logic                         sat_q, sat_d;

  logic                         beat;
  logic                         last_beat;
  logic signed [ACC_WIDTH-1:0]  sum_full;
  logic signed [ACC_WIDTH:0]    rnd_sum;
  logic signed [ACC_WIDTH:0]    r_full;
  logic                         sat_hi;
  logic                         sat_lo;
  logic signed [OUT_WIDTH-1:0]  res_sat;

  assign beat      = prod_valid && (state_q == S_ACC);
  assign last_beat = (count_q == (len_q - 1'b1));

  // Running sum including the current beat; the last beat's result is taken
  // straight from here so res_valid follows the last beat by one cycle.
  assign sum_full = acc_q + {{(ACC_WIDTH-PROD_WIDTH){prod_din[PROD_WIDTH-1]}}, prod_din};
  assign rnd_sum  = {sum_full[ACC_WIDTH-1], sum_full} + RND_HALF;
  assign r_full   = rnd_sum >>> FRAC_SHIFT;
  assign sat_hi   = (r_full > SAT_MAX);
  assign sat_lo   = (r_full < SAT_MIN);
  assign res_sat  = sat_hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
                    sat_lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                             r_full[OUT_WIDTH-1:0];

  // State register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (len == '0) ? S_OUT : S_ACC;
      S_ACC:  if (beat && last_beat) state_d = S_OUT;
      S_OUT:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend on state only
  always_comb begin
    prod_ready = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      S_ACC: begin
        prod_ready = 1'b1;
        busy       = 1'b1;
      end
      S_OUT: begin
        res_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign res_dout = res_q;
  assign sat_flag = sat_q;

  // Datapath next-state
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    res_d   = res_q;
    sat_d   = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = '0;
          count_d = '0;
          if (len == '0) begin
            res_d = '0;
            sat_d = 1'b0;
          end
        end
      end
      S_ACC: begin
        if (beat) begin
          acc_d   = sum_full;
          count_d = count_q + 1'b1;
          if (last_beat) begin
            res_d = res_sat;
            sat_d = sat_hi || sat_lo;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_fpga_test_step_mac_acc.sv
// Directed bench for fpga_test_step_mac_acc with hand-computed expectations.

module tb_fpga_test_step_mac_acc;

  logic               ap_clk;
  logic               ap_rst;
  logic               start;
  logic [7:0]         len;
  logic signed [29:0] prod_din;
  logic               prod_valid;
  logic               prod_ready;
  logic signed [15:0] res_dout;
  logic               res_valid;
  logic               res_ready;
  logic               sat_flag;
  logic               busy;

  int n_vec;
  int n_err;

  fpga_test_step_mac_acc dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .start      (start),
    .len        (len),
    .prod_din   (prod_din),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .res_dout   (res_dout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .sat_flag   (sat_flag),
    .busy       (busy)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic start_burst(input int n);
    start = 1'b1;
    len   = 8'(n);
    tick();
    start = 1'b0;
    len   = 8'hAA;
  endtask

  task automatic send_beats(input string tag, input int n, input int val);
    for (int i = 0; i < n; i++) begin
      prod_valid = 1'b1;
      prod_din   = 30'(val);
      if (i == 0) chk({tag, "_prod_ready"}, 32'(prod_ready), 1);
      tick();
    end
    prod_valid = 1'b0;
    prod_din   = '0;
  endtask

  task automatic take_result(input string tag, input int exp_dout, input int exp_sat);
    chk({tag, "_res_valid"}, 32'(res_valid), 1);
    chk({tag, "_res_dout"}, $signed(res_dout), exp_dout);
    chk({tag, "_sat_flag"}, 32'(sat_flag), exp_sat);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(res_valid), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic burst(input string tag, input int n, input int val,
                       input int exp_dout, input int exp_sat);
    start_burst(n);
    send_beats(tag, n, val);
    take_result(tag, exp_dout, exp_sat);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    ap_rst     = 1'b1;
    start      = 1'b0;
    len        = '0;
    prod_din   = '0;
    prod_valid = 1'b0;
    res_ready  = 1'b0;

    #12;
    chk("rst_prod_ready", 32'(prod_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_dout", $signed(res_dout), 0);
    chk("rst_sat_flag", 32'(sat_flag), 0);
    chk("rst_busy", 32'(busy), 0);
    ap_rst = 1'b0;
    tick();

    // len=1, 100.0 in Q14 with valid held high
    start_burst(1);
    chk("basic_busy", 32'(busy), 1);
    prod_valid = 1'b1;
    prod_din   = 30'sd1638400;
    chk("basic_prod_ready", 32'(prod_ready), 1);
    chk("basic_no_early_valid", 32'(res_valid), 0);
    tick();
    chk("basic_ready_one_cycle", 32'(prod_ready), 0);
    prod_valid = 1'b0;
    take_result("basic", 100, 0);

    // Rounding
    burst("rnd_p8192", 1, 8192, 1, 0);
    burst("rnd_m8192", 1, -8192, 0, 0);
    burst("rnd_p24575", 1, 24575, 1, 0);
    burst("rnd_m24577", 1, -24577, -2, 0);

    // Saturation
    burst("sat_pos4", 4, 268435456, 32767, 1);
    burst("sat_neg4", 4, -268435456, -32768, 1);
    burst("sat_neg255", 255, -268435456, -32768, 1);

    // Stalls: valid pattern 1,0,0,1,0,1 carrying 16384, 32768, -16384
    start_burst(3);
    prod_valid = 1'b1; prod_din = 30'sd16384;  tick();
    prod_valid = 1'b0; prod_din = 30'sd999999; tick();
    chk("stall_hold_ready", 32'(prod_ready), 1);
    tick();
    prod_valid = 1'b1; prod_din = 30'sd32768;  tick();
    prod_valid = 1'b0; prod_din = -30'sd77777; tick();
    chk("stall_no_valid", 32'(res_valid), 0);
    prod_valid = 1'b1; prod_din = -30'sd16384; tick();
    prod_valid = 1'b0; prod_din = '0;
    // Backpressure with start pulses that must be ignored
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len   = 8'd1;
      chk("bp_res_valid", 32'(res_valid), 1);
      chk("bp_res_dout", $signed(res_dout), 2);
      chk("bp_busy", 32'(busy), 1);
      tick();
    end
    start = 1'b0;
    take_result("stall", 2, 0);
    chk("stall_idle_ready", 32'(prod_ready), 0);

    // Empty burst: no beats are accepted
    prod_valid = 1'b1;
    prod_din   = 30'sd1638400;
    start_burst(0);
    chk("len0_prod_ready", 32'(prod_ready), 0);
    prod_valid = 1'b0;
    take_result("len0", 0, 0);

    // Reset after 2 of 5 beats
    start_burst(5);
    send_beats("abort", 2, 16384);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("abort_prod_ready", 32'(prod_ready), 0);
    chk("abort_res_valid", 32'(res_valid), 0);
    chk("abort_res_dout", $signed(res_dout), 0);
    chk("abort_sat_flag", 32'(sat_flag), 0);
    chk("abort_busy", 32'(busy), 0);
    #1;
    ap_rst = 1'b0;
    tick();
    burst("after_abort", 2, 16384, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
